// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants: default pixel width, per-layer feature-map
// geometry and the helper used to size row/column counters.
package cnn_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   localparam int CONV1_IMG_W = 26;
   localparam int CONV1_IMG_H = 26;
   localparam int POOL1_IMG_W = CONV1_IMG_W / 2;
   localparam int POOL1_IMG_H = CONV1_IMG_H / 2;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CONV1_COL_W = cntWidth(CONV1_IMG_W);
   localparam int CONV1_ROW_W = cntWidth(CONV1_IMG_H);

endpackage

// File: rtl/pool22_row_buffer.sv
// Half-width line store holding the even-row pair maxima until the odd row
// that closes each 2x2 window reads them back (combinational read).
module pool22_row_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 13,
   parameter int AW         = 4
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/pool22_maxpool.sv
// Streaming 2x2 stride-2 max pooling over a raster-ordered feature map with
// no backpressure; one pooled pixel leaves one cycle after its window closes.
module pool22_maxpool #(
   parameter int DATA_WIDTH = cnn_pkg::DEFAULT_DATA_WIDTH,
   parameter int IMG_W      = cnn_pkg::CONV1_IMG_W,
   parameter int IMG_H      = cnn_pkg::CONV1_IMG_H,
   parameter int SIGNED_CMP = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  frame_done
);

   import cnn_pkg::*;

   localparam int CW     = cntWidth(IMG_W);
   localparam int RW     = cntWidth(IMG_H);
   localparam int HALF_W = IMG_W / 2;
   localparam int HALF_H = IMG_H / 2;
   localparam int AW     = cntWidth(HALF_W);

   localparam logic [CW-1:0] LAST_COL     = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW     = RW'(IMG_H - 1);
   localparam logic [CW-1:0] LAST_WIN_COL = CW'(2 * HALF_W - 1);
   localparam logic [RW-1:0] LAST_WIN_ROW = RW'(2 * HALF_H - 1);
   localparam bit            ODD_H        = (IMG_H % 2) != 0;

   function automatic logic [DATA_WIDTH-1:0] maxOf(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
      if (SIGNED_CMP != 0) begin
         return ($signed(a) >= $signed(b)) ? a : b;
      end
      return (a >= b) ? a : b;
   endfunction

   logic [CW-1:0]         colQ, colD;
   logic [RW-1:0]         rowQ, rowD;
   logic [DATA_WIDTH-1:0] pairQ, pairD;
   logic                  outValidQ;
   logic [DATA_WIDTH-1:0] outDataQ, outDataD;
   logic                  frameDoneQ;

   logic [DATA_WIDTH-1:0] pairMax;
   logic [DATA_WIDTH-1:0] rbRdata;
   logic [AW-1:0]         rbAddr;
   logic                  rowUsable;
   logic                  wrEn;
   logic                  fire;
   logic                  lastWin;

   // An odd trailing row still advances the counters but never touches the buffer.
   always_comb begin
      pairMax   = maxOf(pairQ, in_data);
      rbAddr    = AW'(colQ >> 1);
      rowUsable = !(ODD_H && (rowQ == LAST_ROW));
      wrEn      = in_valid && colQ[0] && !rowQ[0] && rowUsable;
      fire      = in_valid && colQ[0] && rowQ[0];
      lastWin   = (colQ == LAST_WIN_COL) && (rowQ == LAST_WIN_ROW);

      colD     = colQ;
      rowD     = rowQ;
      pairD    = pairQ;
      outDataD = outDataQ;
      if (in_valid) begin
         if (colQ == LAST_COL) begin
            colD = '0;
            rowD = (rowQ == LAST_ROW) ? '0 : rowQ + RW'(1);
         end else begin
            colD = colQ + CW'(1);
         end
         if (!colQ[0]) begin
            pairD = in_data;
         end
      end
      if (fire) begin
         outDataD = maxOf(pairMax, rbRdata);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         colQ       <= '0;
         rowQ       <= '0;
         pairQ      <= '0;
         outValidQ  <= 1'b0;
         outDataQ   <= '0;
         frameDoneQ <= 1'b0;
      end else begin
         colQ       <= colD;
         rowQ       <= rowD;
         pairQ      <= pairD;
         outValidQ  <= fire;
         outDataQ   <= outDataD;
         frameDoneQ <= fire && lastWin;
      end
   end

   pool22_row_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (HALF_W),
      .AW         (AW)
   ) u_row_buffer (
      .clk       (clk),
      .wr_en_i   (wrEn),
      .wr_addr_i (rbAddr),
      .wr_data_i (pairMax),
      .rd_addr_i (rbAddr),
      .rd_data_o (rbRdata)
   );

   assign out_valid  = outValidQ;
   assign out_data   = outDataQ;
   assign frame_done = frameDoneQ;

endmodule
